commit_trace_fifo: RTL and testbench

COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

---
 rtl/commit_trace_fifo_if.sv | 25 ++
 rtl/commit_trace_fifo.sv | 110 +++++++++++
 tb/tb_commit_trace_fifo.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_fifo_if.sv
// Commit/trace handshake bundle for commit_trace_fifo.
//   commit_en/commit_pc/commit_instr : retirement stream from the core
//   trace_valid/trace_ready          : head-entry valid/ready handshake
//   trace_pc/trace_instr/trace_seq   : head-entry fields
// master = core + trace consumer side, slave = the FIFO.
interface commit_trace_fifo_if;
  logic        commit_en;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [15:0] trace_seq;

  modport master (
    output commit_en, commit_pc, commit_instr, trace_ready,
    input  trace_valid, trace_pc, trace_instr, trace_seq
  );

  modport slave (
    input  commit_en, commit_pc, commit_instr, trace_ready,
    output trace_valid, trace_pc, trace_instr, trace_seq
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: buffers retired-instruction records {pc, instr, seq}
// for a trace consumer. Every commit_en cycle consumes a sequence number,
// so gaps in trace_seq expose dropped or flushed commits.
// Ports:
//   clk, resetn : clock, async active-low reset
//   tif         : commit input / trace output handshake (slave modport)
//   clear       : sync flush of entries, overflow and drop_cnt (seq kept)
//   level       : occupancy 0..DEPTH
//   overflow    : sticky, set when a commit was dropped
//   drop_cnt    : saturating count of dropped commits
module commit_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               resetn,
  commit_trace_fifo_if.slave tif,
  input  logic               clear,
  output logic [PTR_W:0]     level,
  output logic               overflow,
  output logic [15:0]        drop_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] seq;
  } entry_t;

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic [15:0]      seq_q, seq_d;
  logic [15:0]      drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, push, drop;

  assign full = (level_q == FULL_LVL);
  assign pop  = (level_q != '0) && tif.trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = tif.commit_en && (!full || pop);
  assign drop = tif.commit_en && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    // seq counts every commit, including dropped and cleared ones.
    seq_d    = seq_q + {15'd0, tif.commit_en};
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (PTR_W+1)'(1);
        2'b01:   level_d = level_q - (PTR_W+1)'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; outputs are qualified by trace_valid.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem_q[wr_ptr_q] <= '{pc: tif.commit_pc, instr: tif.commit_instr, seq: seq_q};
  end

  assign head            = mem_q[rd_ptr_q];
  assign tif.trace_valid = (level_q != '0);
  assign tif.trace_pc    = head.pc;
  assign tif.trace_instr = head.instr;
  assign tif.trace_seq   = head.seq;
  assign level           = level_q;
  assign overflow        = ovf_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo (DEPTH=8).
module tb_commit_trace_fifo;
  logic        clk;
  logic        resetn;
  logic        clear;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  int          n_chk;
  int          n_pass;

  commit_trace_fifo_if tif();

  commit_trace_fifo #(.DEPTH(8), .PTR_W(3)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tif      (tif),
    .clear    (clear),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tif.commit_en    = 1'b0;
    tif.commit_pc    = '0;
    tif.commit_instr = '0;
    tif.trace_ready  = 1'b0;
    clear            = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #2;
    n_chk++; if (tif.trace_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", tif.trace_valid); else n_pass++;
    n_chk++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
    cyc();
    resetn = 1'b1;
    // trace_ready on an empty FIFO does nothing.
    tif.trace_ready = 1'b1;
    cyc();
    tif.trace_ready = 1'b0;
    n_chk++; if (level !== 4'd0 || tif.trace_valid !== 1'b0)
      $display("FAIL empty_pop: got level=%0d valid=%b want 0/0", level, tif.trace_valid); else n_pass++;
  endtask

  task automatic test_single_entry();
    int bad;
    do_reset();
    tif.commit_en = 1'b1; tif.commit_pc = 32'h8000_0000; tif.commit_instr = 32'h0000_0013;
    cyc();
    idle();
    n_chk++; if (tif.trace_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", tif.trace_valid); else n_pass++;
    n_chk++; if (tif.trace_pc !== 32'h8000_0000) $display("FAIL single_pc: got %h want 80000000", tif.trace_pc); else n_pass++;
    n_chk++; if (tif.trace_instr !== 32'h0000_0013) $display("FAIL single_instr: got %h want 00000013", tif.trace_instr); else n_pass++;
    n_chk++; if (tif.trace_seq !== 16'd0) $display("FAIL single_seq: got %0d want 0", tif.trace_seq); else n_pass++;
    n_chk++; if (level !== 4'd1) $display("FAIL single_level: got %0d want 1", level); else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (tif.trace_valid !== 1'b1 || tif.trace_pc !== 32'h8000_0000 ||
          tif.trace_instr !== 32'h0000_0013 || tif.trace_seq !== 16'd0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL single_hold: got %0d unstable cycles want 0", bad); else n_pass++;
    tif.trace_ready = 1'b1;
    cyc();
    tif.trace_ready = 1'b0;
    n_chk++; if (tif.trace_valid !== 1'b0 || level !== 4'd0)
      $display("FAIL single_pop: got valid=%b level=%0d want 0/0", tif.trace_valid, level); else n_pass++;
  endtask

  task automatic test_fill_drop();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tif.commit_en = 1'b1; tif.commit_pc = 32'h1000 + 32'(4*i); tif.commit_instr = 32'(i);
      cyc();
    end
    idle();
    n_chk++; if (level !== 4'd8) $display("FAIL fill_level: got %0d want 8", level); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL fill_ovf: got %b want 1", overflow); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd2) $display("FAIL fill_drop: got %0d want 2", drop_cnt); else n_pass++;
    tif.trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (tif.trace_seq !== 16'(i) || tif.trace_pc !== 32'h1000 + 32'(4*i))
        $display("FAIL drain_entry%0d: got seq=%0d pc=%h want seq=%0d pc=%h",
                 i, tif.trace_seq, tif.trace_pc, i, 32'h1000 + 32'(4*i)); else n_pass++;
      cyc();
    end
    tif.trace_ready = 1'b0;
    n_chk++; if (tif.trace_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", tif.trace_valid); else n_pass++;
    n_chk++; if (overflow !== 1'b1 || drop_cnt !== 16'd2)
      $display("FAIL ovf_sticky: got ovf=%b drop=%0d want 1/2", overflow, drop_cnt); else n_pass++;
  endtask

  // Continues from test_fill_drop: seq counter is at 10, drop_cnt=2.
  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) begin
      tif.commit_en = 1'b1; tif.commit_pc = 32'h2000 + 32'(4*i); tif.commit_instr = 32'(i);
      cyc();
    end
    n_chk++; if (level !== 4'd8) $display("FAIL fullpop_pre_level: got %0d want 8", level); else n_pass++;
    tif.commit_pc = 32'h0000_0ABC; tif.commit_instr = 32'h55; tif.trace_ready = 1'b1;
    cyc();
    idle();
    n_chk++; if (level !== 4'd8) $display("FAIL fullpop_level: got %0d want 8", level); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd2) $display("FAIL fullpop_drop: got %0d want 2", drop_cnt); else n_pass++;
    tif.trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (tif.trace_seq !== 16'(11 + i))
        $display("FAIL fullpop_seq%0d: got %0d want %0d", i, tif.trace_seq, 11 + i); else n_pass++;
      if (i == 7) begin
        n_chk++; if (tif.trace_pc !== 32'h0000_0ABC)
          $display("FAIL fullpop_tail_pc: got %h want 00000abc", tif.trace_pc); else n_pass++;
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_seq_wrap();
    int bad;
    do_reset();
    bad = 0;
    tif.trace_ready = 1'b1;
    tif.commit_en   = 1'b1;
    for (int i = 0; i < 32'h10002; i++) begin
      tif.commit_pc = 32'(i);
      cyc();
      // Steady state: one push and one pop per cycle, head is the latest commit.
      if (tif.trace_seq !== 16'(i)) bad++;
      if (i == 32'hFFFF) begin
        n_chk++; if (tif.trace_seq !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", tif.trace_seq); else n_pass++;
      end
      if (i == 32'h10000) begin
        n_chk++; if (tif.trace_seq !== 16'h0000) $display("FAIL wrap_0000: got %h want 0000", tif.trace_seq); else n_pass++;
      end
      if (i == 32'h10001) begin
        n_chk++; if (tif.trace_seq !== 16'h0001) $display("FAIL wrap_0001: got %h want 0001", tif.trace_seq); else n_pass++;
      end
    end
    idle();
    n_chk++; if (bad != 0) $display("FAIL wrap_stream: got %0d bad heads want 0", bad); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0 || overflow !== 1'b0 || level !== 4'd1)
      $display("FAIL wrap_nodrop: got drop=%0d ovf=%b level=%0d want 0/0/1", drop_cnt, overflow, level); else n_pass++;
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tif.commit_en = 1'b1; tif.commit_pc = 32'(i);
      cyc();
    end
    idle();
    tif.trace_ready = 1'b1;
    repeat (5) cyc();
    idle();
    n_chk++; if (level !== 4'd3 || overflow !== 1'b1 || drop_cnt !== 16'd1)
      $display("FAIL clear_pre: got level=%0d ovf=%b drop=%0d want 3/1/1", level, overflow, drop_cnt); else n_pass++;
    // Commit seq 9 is swallowed by the clear but still consumes a number.
    clear = 1'b1; tif.commit_en = 1'b1; tif.trace_ready = 1'b1;
    cyc();
    idle();
    n_chk++; if (level !== 4'd0 || tif.trace_valid !== 1'b0)
      $display("FAIL clear_level: got level=%0d valid=%b want 0/0", level, tif.trace_valid); else n_pass++;
    n_chk++; if (overflow !== 1'b0 || drop_cnt !== 16'd0)
      $display("FAIL clear_flags: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); else n_pass++;
    tif.commit_en = 1'b1; tif.commit_pc = 32'h3000;
    cyc();
    idle();
    n_chk++; if (tif.trace_seq !== 16'd10 || level !== 4'd1)
      $display("FAIL clear_nextseq: got seq=%0d level=%0d want 10/1", tif.trace_seq, level); else n_pass++;
  endtask

  // Continues from test_clear with one entry held.
  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      tif.commit_en = 1'b1; tif.commit_pc = 32'h4000 + 32'(i);
      cyc();
    end
    idle();
    n_chk++; if (level !== 4'd5) $display("FAIL areset_pre: got %0d want 5", level); else n_pass++;
    #2;
    resetn = 1'b0;
    #1;
    n_chk++; if (tif.trace_valid !== 1'b0 || level !== 4'd0)
      $display("FAIL areset_now: got valid=%b level=%0d want 0/0", tif.trace_valid, level); else n_pass++;
    #1;
    resetn = 1'b1;
    tif.commit_en = 1'b1; tif.commit_pc = 32'h5000;
    cyc();
    idle();
    n_chk++; if (tif.trace_seq !== 16'd0 || level !== 4'd1 || tif.trace_pc !== 32'h5000)
      $display("FAIL areset_first: got seq=%0d level=%0d pc=%h want 0/1/00005000",
               tif.trace_seq, level, tif.trace_pc); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    resetn = 1'b0;
    idle();
    test_reset();
    test_single_entry();
    test_fill_drop();
    test_full_pop();
    test_clear();
    test_async_reset();
    test_seq_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
